// File: rtl/craft_pkg.sv
// -----------------------------------------------------------------------------
// craft_pkg
//   Shared types, permutation tables and helper functions for the CRAFT-64
//   iterative core.
//
//   State convention: a 64-bit block holds 16 nibbles, nibble 0 at [63:60].
//   Nibble i sits at row i/4, column i%4 of the 4x4 cipher state.
// -----------------------------------------------------------------------------
package craft_pkg;

  typedef logic [63:0]      craft_state_t;
  typedef logic [3:0][63:0] craft_tk_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } craft_fsm_t;

  // Longest round count the RC generator has to reach.
  localparam int CRAFT_MAX_ROUNDS = 32;

  // Tweak permutation: nibble i of Q(T) is nibble CRAFT_Q_PERM[i] of T.
  localparam int CRAFT_Q_PERM [16] = '{12, 10, 15, 5, 14, 8, 9, 2,
                                        11, 3, 7, 4, 6, 0, 1, 13};

  // Nibble permutation: nibble i moves to position CRAFT_PN_PERM[i].
  // The table is an involution, so the direction of use is immaterial.
  localparam int CRAFT_PN_PERM [16] = '{15, 12, 13, 14, 10, 9, 8, 11,
                                         6, 5, 4, 7, 1, 2, 3, 0};

  localparam logic [3:0] CRAFT_SBOX [16] = '{4'hc, 4'ha, 4'hd, 4'h3,
                                             4'he, 4'hb, 4'hf, 4'h7,
                                             4'h8, 4'h9, 4'h1, 4'h5,
                                             4'h0, 4'h2, 4'h4, 4'h6};

  function automatic logic [3:0] craft_nib(input craft_state_t s, input int i);
    return s[63-4*i -: 4];
  endfunction

  // Round constant for round r: two small LFSRs stepped r times from their
  // seeds. The loop has a fixed trip count so it unrolls into a mux tree
  // when r is driven from the round counter.
  function automatic logic [7:0] craft_rc(input int r);
    logic [3:0] a;
    logic [2:0] b;
    a = 4'b0001;
    b = 3'b001;
    for (int k = 0; k < CRAFT_MAX_ROUNDS; k++) begin
      if (k < r) begin
        a = {a[1] ^ a[0], a[3:1]};
        b = {b[1] ^ b[0], b[2:1]};
      end
    end
    return {a, 1'b0, b};
  endfunction

  function automatic craft_state_t craft_q(input craft_state_t t);
    craft_state_t q;
    q = '0;
    for (int i = 0; i < 16; i++) begin
      q[63-4*i -: 4] = craft_nib(t, CRAFT_Q_PERM[i]);
    end
    return q;
  endfunction

  // TK0=K0^T, TK1=K1^T, TK2=K0^Q(T), TK3=K1^Q(T); round r uses TK[r mod 4].
  function automatic craft_tk_t craft_tweakey(input logic [127:0] key,
                                              input craft_state_t tweak);
    craft_tk_t    tk;
    craft_state_t tq;
    tq    = craft_q(tweak);
    tk[0] = key[127:64] ^ tweak;
    tk[1] = key[63:0]   ^ tweak;
    tk[2] = key[127:64] ^ tq;
    tk[3] = key[63:0]   ^ tq;
    return tk;
  endfunction

endpackage

// File: rtl/craft_round.sv
// -----------------------------------------------------------------------------
// craft_round
//   One combinational CRAFT round:
//     MixColumn -> AddConst (row 1) -> AddTweakey -> PermuteNibbles -> SBox
//
// Ports
//   din      in   64  round input state
//   rc       in    8  round constant {a[3:0], 1'b0, b[2:0]}
//   tk       in   64  tweakey word for this round
//   add_key  out  64  state after AddTweakey (result of the final round)
//   dout     out  64  full round result
// -----------------------------------------------------------------------------
module craft_round
  import craft_pkg::*;
(
  input  craft_state_t din,
  input  logic [7:0]   rc,
  input  craft_state_t tk,
  output craft_state_t add_key,
  output craft_state_t dout
);

  craft_state_t mc;
  craft_state_t arc;

  // MixColumn with M = [1 0 1 1; 0 1 0 1; 0 0 1 0; 0 0 0 1]:
  // only rows 0 and 1 change.
  always_comb begin
    mc = din;
    for (int c = 0; c < 4; c++) begin
      mc[63-4*c -: 4]     = craft_nib(din, c) ^ craft_nib(din, 8 + c) ^
                            craft_nib(din, 12 + c);
      mc[63-4*(4+c) -: 4] = craft_nib(din, 4 + c) ^ craft_nib(din, 12 + c);
    end
  end

  // RC lands on nibbles 4 (a) and 5 ({0,b}), i.e. bits [47:40].
  assign arc     = mc ^ {16'h0000, rc, 40'h00_0000_0000};
  assign add_key = arc ^ tk;

  always_comb begin
    dout = '0;
    for (int i = 0; i < 16; i++) begin
      dout[63-4*CRAFT_PN_PERM[i] -: 4] = CRAFT_SBOX[craft_nib(add_key, i)];
    end
  end

endmodule

// File: rtl/craft_iter_core.sv
// -----------------------------------------------------------------------------
// craft_iter_core
//   Iterative CRAFT-64 encryption core (64-bit block, 128-bit key, 64-bit
//   tweak). Executes UNROLL rounds per clock until ROUNDS rounds are done,
//   then presents the ciphertext until the consumer takes it.
//
// Parameters
//   UNROLL  rounds per clock: 1, 2, 4, 8, 16 or 32, and must divide ROUNDS
//   ROUNDS  total rounds (32 for full CRAFT; fewer only for reduced-round test)
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous, active-low reset
//   in_valid   in   1    request valid
//   in_ready   out  1    core can accept a request (IDLE only)
//   in_pt      in   64   plaintext, nibble 0 = [63:60]
//   in_key     in   128  K0 = [127:64], K1 = [63:0]
//   in_tweak   in   64   tweak, nibble 0 = [63:60]
//   out_valid  out  1    ciphertext valid (DONE)
//   out_ready  in   1    consumer accepts ciphertext
//   out_ct     out  64   ciphertext, held stable while out_valid
//   busy       out  1    high in RUN or DONE
// -----------------------------------------------------------------------------
module craft_iter_core
  import craft_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_pt,
  input  logic [127:0] in_key,
  input  logic [63:0]  in_tweak,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_ct,
  output logic         busy
);

  localparam int CYCLES = ROUNDS / UNROLL;
  localparam int CNT_W  = $clog2(CYCLES) + 1;

  craft_fsm_t       state;
  logic [CNT_W-1:0] cnt;
  craft_state_t     blk_p0;
  craft_tk_t        tk_p0;
  craft_state_t     rnd_res;

  // ---- round chain: blk_p0 -> UNROLL combinational rounds -> rnd_res ----
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    int           r;
    logic [7:0]   rc;
    craft_state_t tk;
    craft_state_t din;
    craft_state_t add_key;
    craft_state_t dout;
    craft_state_t res;

    // With UNROLL >= 4 the tweakey index folds to the constant j mod 4.
    always_comb begin
      r  = int'(cnt) * UNROLL + j;
      rc = craft_rc(r);
      tk = tk_p0[r[1:0]];
    end

    if (j == 0) begin : g_first
      assign din = blk_p0;
    end else begin : g_next
      assign din = g_round[j-1].res;
    end

    craft_round u_round (
      .din     (din),
      .rc      (rc),
      .tk      (tk),
      .add_key (add_key),
      .dout    (dout)
    );

    // The last cipher round stops after AddTweakey. Because UNROLL divides
    // ROUNDS this can only be true in the last slot of the last cycle.
    assign res = (r == ROUNDS - 1) ? add_key : dout;
  end

  assign rnd_res = g_round[UNROLL-1].res;

  // ---- control FSM and state registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_ct    <= '0;
      cnt       <= '0;
      blk_p0    <= '0;
      tk_p0     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            blk_p0   <= in_pt;
            tk_p0    <= craft_tweakey(in_key, in_tweak);
            cnt      <= '0;
            state    <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          blk_p0 <= rnd_res;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(CYCLES - 1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_ct    <= rnd_res;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
